// File: rtl/pe_mac_sequencer.sv
// Purpose: sequences one pe_unit through a multi-tile, multi-slot dot-product job and tags its results.
// Latency: MAC issue is combinational on op_valid; results return PE_LAT cycles after pe_rounder_en.
// Backpressure: op_ready only with op_valid in RUN; a slot finalised in the last two cycles stalls with a bubble.
module pe_mac_sequencer #(
    parameter int NUM_SLOTS = 8,
    parameter int K_W       = 10,
    parameter int TILE_W    = 8,
    parameter int PE_LAT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [K_W-1:0]    cfg_k,
    input  logic [3:0]        cfg_slots,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic              op_valid,
    output logic              op_ready,
    output logic [3:0]        pe_add_number,
    output logic              pe_rounder_en,
    output logic              pe_op_zero,
    output logic              pe_keep,
    input  logic              pe_rounder_valid,
    output logic              res_valid,
    output logic [2:0]        res_slot,
    output logic [TILE_W-1:0] res_tile,
    output logic              busy,
    output logic              done
);

    localparam int SLOT_W = 3;
    localparam int CNT_W  = TILE_W + 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q;
    logic [K_W-1:0]      cfg_k_q;
    logic [3:0]          cfg_slots_q;
    logic [TILE_W-1:0]   cfg_tiles_q;
    logic [K_W-1:0]      k_q, k_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [CNT_W-1:0]    res_cnt_q;
    logic                fin1_vld_q, fin2_vld_q;
    logic [SLOT_W-1:0]   fin1_slot_q, fin2_slot_q;
    logic [SLOT_W-1:0]   tag_slot_q [PE_LAT];
    logic [TILE_W-1:0]   tag_tile_q [PE_LAT];

    logic                held, issue, last_slot, last_k, last_tile, final_mac, job_end;
    logic [SLOT_W-1:0]   free_slot;
    logic [3:0]          slots_clamped;
    logic [CNT_W-1:0]    res_total;

    // The pe clears a finalised slot three cycles later, so that slot may not be addressed in between.
    assign held      = (fin1_vld_q && (fin1_slot_q == slot_q)) ||
                       (fin2_vld_q && (fin2_slot_q == slot_q));
    assign issue     = (state_q == RUN) && op_valid && !held;
    assign last_slot = ({1'b0, slot_q} == (cfg_slots_q - 4'd1));
    assign last_k    = (k_q == (cfg_k_q - K_W'(1)));
    assign last_tile = (tile_q == (cfg_tiles_q - TILE_W'(1)));
    assign final_mac = issue && last_k;
    assign job_end   = issue && last_slot && last_k && last_tile;

    assign slots_clamped = (cfg_slots > 4'd8) ? 4'd8 : cfg_slots;
    assign res_total     = CNT_W'(cfg_slots_q) * CNT_W'(cfg_tiles_q);

    // Bubble address: lowest slot outside the hold-off set, so a bubble never touches a slot awaiting its clear.
    always_comb begin
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!((fin1_vld_q && (fin1_slot_q == SLOT_W'(i))) ||
                  (fin2_vld_q && (fin2_slot_q == SLOT_W'(i))))) begin
                free_slot = SLOT_W'(i);
            end
        end
    end

    // Issue order is tile-major, then k, then slot innermost.
    always_comb begin
        slot_d = slot_q;
        k_d    = k_q;
        tile_d = tile_q;
        if (issue) begin
            if (last_slot) begin
                slot_d = '0;
                if (last_k) begin
                    k_d    = '0;
                    tile_d = tile_q + TILE_W'(1);
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    assign op_ready      = issue;
    assign pe_op_zero    = !issue;
    assign pe_rounder_en = final_mac;
    assign pe_add_number = issue ? {1'b0, slot_q} : {1'b0, free_slot};
    assign pe_keep       = 1'b0;
    assign res_valid     = pe_rounder_valid && ((state_q == RUN) || (state_q == DRAIN));
    assign res_slot      = tag_slot_q[PE_LAT-1];
    assign res_tile      = tag_tile_q[PE_LAT-1];
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

    // Job FSM: config latch, issue counters, hold-off history and result counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_k_q     <= '0;
            cfg_slots_q <= '0;
            cfg_tiles_q <= '0;
            k_q         <= '0;
            slot_q      <= '0;
            tile_q      <= '0;
            res_cnt_q   <= '0;
            fin1_vld_q  <= 1'b0;
            fin2_vld_q  <= 1'b0;
            fin1_slot_q <= '0;
            fin2_slot_q <= '0;
        end else begin
            fin1_vld_q  <= final_mac;
            fin1_slot_q <= slot_q;
            fin2_vld_q  <= fin1_vld_q;
            fin2_slot_q <= fin1_slot_q;
            k_q         <= k_d;
            slot_q      <= slot_d;
            tile_q      <= tile_d;
            if (res_valid) begin
                res_cnt_q <= res_cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cfg_k_q     <= cfg_k;
                        cfg_slots_q <= slots_clamped;
                        cfg_tiles_q <= cfg_tiles;
                        k_q         <= '0;
                        slot_q      <= '0;
                        tile_q      <= '0;
                        res_cnt_q   <= '0;
                        if ((cfg_k == '0) || (cfg_slots == '0) || (cfg_tiles == '0)) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (job_end) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (res_cnt_q == res_total) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag shift: the tail holds the {slot, tile} that was being issued PE_LAT cycles ago.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PE_LAT; i++) begin
                tag_slot_q[i] <= '0;
                tag_tile_q[i] <= '0;
            end
        end else begin
            tag_slot_q[0] <= slot_q;
            tag_tile_q[0] <= tile_q;
            for (int i = 1; i < PE_LAT; i++) begin
                tag_slot_q[i] <= tag_slot_q[i-1];
                tag_tile_q[i] <= tag_tile_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Purpose: directed self-checking bench for pe_mac_sequencer with a PE_LAT-deep pe_unit rounder model.
// Latency: cycle 0 is the first cycle after the start edge; all expectations are in those cycle numbers.
// Backpressure: op_valid is driven always-on or toggling; op_ready is checked against it.
module tb_pe_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] cfg_k;
    logic [3:0] cfg_slots;
    logic [7:0] cfg_tiles;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] pe_add_number;
    logic       pe_rounder_en;
    logic       pe_op_zero;
    logic       pe_keep;
    logic       pe_rounder_valid;
    logic       res_valid;
    logic [2:0] res_slot;
    logic [7:0] res_tile;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    pe_mac_sequencer #(.NUM_SLOTS(8), .K_W(10), .TILE_W(8), .PE_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_slots(cfg_slots),
        .cfg_tiles(cfg_tiles), .op_valid(op_valid), .op_ready(op_ready),
        .pe_add_number(pe_add_number), .pe_rounder_en(pe_rounder_en), .pe_op_zero(pe_op_zero),
        .pe_keep(pe_keep), .pe_rounder_valid(pe_rounder_valid), .res_valid(res_valid),
        .res_slot(res_slot), .res_tile(res_tile), .busy(busy), .done(done)
    );

    // pe_unit rounder model: valid three cycles after rounder_en, sharing rst_n.
    logic [2:0] pe_sr;
    always @(posedge clk) begin
        if (!rst_n) pe_sr <= 3'b000;
        else        pe_sr <= {pe_sr[1:0], pe_rounder_en};
    end
    assign pe_rounder_valid = pe_sr[2];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    int iss_cyc[$];
    int iss_slot[$];
    int bub_cyc[$];
    int bub_addn[$];
    int ren_cyc[$];
    int res_cyc[$];
    int res_s[$];
    int res_t[$];
    int done_cnt, done_cyc, opr_wo_valid, zero_bad, keep_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job from the start pulse; mode 1 toggles op_valid, hold keeps start high with other cfg.
    task automatic run_job(input int k, input int s, input int t, input int mode, input bit hold,
                           input int budget);
        iss_cyc.delete(); iss_slot.delete(); bub_cyc.delete(); bub_addn.delete();
        ren_cyc.delete(); res_cyc.delete(); res_s.delete(); res_t.delete();
        done_cnt = 0; done_cyc = -1; opr_wo_valid = 0; zero_bad = 0; keep_bad = 0;
        start = 1'b1; cfg_k = 10'(k); cfg_slots = 4'(s); cfg_tiles = 8'(t); op_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            op_valid = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            if (hold && c >= 2 && done_cyc < 0) begin
                start = 1'b1; cfg_k = 10'd7; cfg_slots = 4'd2; cfg_tiles = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (op_ready) begin
                iss_cyc.push_back(c);
                iss_slot.push_back(int'(pe_add_number));
                if (!op_valid) opr_wo_valid++;
            end else begin
                bub_cyc.push_back(c);
                bub_addn.push_back(int'(pe_add_number));
            end
            if (op_ready == pe_op_zero) zero_bad++;
            if (pe_keep !== 1'b0) keep_bad++;
            if (pe_rounder_en) ren_cyc.push_back(c);
            if (res_valid) begin
                res_cyc.push_back(c);
                res_s.push_back(int'(res_slot));
                res_t.push_back(int'(res_tile));
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; op_valid = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 1);
    endtask

    // Golden result order: per tile, slots 0..s-1 finalise in order.
    task automatic check_results(input string tag, input int s, input int t);
        chk({tag, "_res_count"}, res_s.size(), s * t);
        for (int i = 0; i < res_s.size() && i < s * t; i++) begin
            chk({tag, "_res_slot"}, res_s[i], i % s);
            chk({tag, "_res_tile"}, res_t[i], i / s);
        end
        chk({tag, "_op_zero"}, zero_bad, 0);
        chk({tag, "_keep"}, keep_bad, 0);
        chk({tag, "_done_once"}, done_cnt, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_k = '0; cfg_slots = '0; cfg_tiles = '0; op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_rounder_en", pe_rounder_en, 0);
        chk("rst_op_zero", pe_op_zero, 1);
        chk("rst_add_number", pe_add_number, 0);
        chk("rst_res_valid", res_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // slots=4, k=3, tiles=1, op_valid always high
        run_job(3, 4, 1, 0, 1'b0, 60);
        chk("t1_issues", iss_cyc.size(), 12);
        if (iss_cyc.size() == 12) begin
            chk("t1_first_issue", iss_cyc[0], 0);
            chk("t1_last_issue", iss_cyc[11], 11);
        end
        chk("t1_ren_count", ren_cyc.size(), 4);
        if (ren_cyc.size() == 4) begin
            chk("t1_ren_first", ren_cyc[0], 8);
            chk("t1_ren_last", ren_cyc[3], 11);
        end
        if (res_cyc.size() == 4) begin
            chk("t1_res_first", res_cyc[0], 11);
            chk("t1_res_last", res_cyc[3], 14);
        end
        chk("t1_done_cycle", done_cyc, 16);
        check_results("t1", 4, 1);
        chk("t1_idle_busy", busy, 0);

        // slots=1, k=2, tiles=2: two hold-off bubbles at the tile boundary
        run_job(2, 1, 2, 0, 1'b0, 60);
        chk("t2_issues", iss_cyc.size(), 4);
        if (iss_cyc.size() == 4) begin
            chk("t2_iss0", iss_cyc[0], 0);
            chk("t2_iss1", iss_cyc[1], 1);
            chk("t2_iss2", iss_cyc[2], 4);
            chk("t2_iss3", iss_cyc[3], 5);
        end
        if (bub_cyc.size() >= 2) begin
            chk("t2_bub0_cyc", bub_cyc[0], 2);
            chk("t2_bub1_cyc", bub_cyc[1], 3);
            chk("t2_bub0_addn", bub_addn[0], 1);
            chk("t2_bub1_addn", bub_addn[1], 1);
        end
        chk("t2_ren_count", ren_cyc.size(), 2);
        chk("t2_done_cycle", done_cyc, 10);
        check_results("t2", 1, 2);

        // slots=8, k=1, tiles=1, op_valid toggling 1010...
        run_job(1, 8, 1, 1, 1'b0, 80);
        chk("t3_issues", iss_cyc.size(), 8);
        chk("t3_ready_wo_valid", opr_wo_valid, 0);
        for (int i = 0; i < iss_slot.size() && i < 8; i++) begin
            chk("t3_iss_slot", iss_slot[i], i);
            chk("t3_iss_cyc", iss_cyc[i], 2 * i);
        end
        chk("t3_ren_count", ren_cyc.size(), 8);
        chk("t3_done_cycle", done_cyc, 19);
        check_results("t3", 8, 1);

        // cfg_k=0: straight to DONE, nothing issued
        run_job(0, 4, 1, 0, 1'b0, 20);
        chk("t4_issues", iss_cyc.size(), 0);
        chk("t4_ren_count", ren_cyc.size(), 0);
        chk("t4_done_cycle", done_cyc, 0);
        chk("t4_done_once", done_cnt, 1);

        // slots=2, k=1, tiles=2 with start held high through the job and its DONE cycle
        run_job(1, 2, 2, 0, 1'b1, 60);
        chk("t5_issues", iss_cyc.size(), 4);
        if (iss_cyc.size() == 4) chk("t5_iss2", iss_cyc[2], 3);
        if (bub_cyc.size() >= 1) begin
            chk("t5_bub0_cyc", bub_cyc[0], 2);
            chk("t5_bub0_addn", bub_addn[0], 2);
        end
        chk("t5_done_cycle", done_cyc, 9);
        check_results("t5", 2, 2);
        chk("t5_idle_busy", busy, 0);

        // reset in the middle of RUN
        start = 1'b1; cfg_k = 10'd3; cfg_slots = 4'd4; cfg_tiles = 8'd1;
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_busy_in_run", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_op_ready", op_ready, 0);
        chk("t6_rst_op_zero", pe_op_zero, 1);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy || res_valid) done_cnt++;
            @(posedge clk); #1;
        end
        chk("t6_quiet_after_rst", done_cnt, 0);
        op_valid = 1'b0;
        run_job(1, 3, 2, 0, 1'b0, 60);
        chk("t6_issues", iss_cyc.size(), 6);
        chk("t6_done_cycle", done_cyc, 10);
        check_results("t6", 3, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
